// File: rtl/spi_mem_ctrl_pkg.sv
// Shared types for the SPI command controller: frame commands, arbiter states, reply hold default.
// No logic; latency n/a.
// Backpressure n/a.
package spi_mem_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ACC_SPI  = 2'd1,
    ARB_ACC_HOST = 2'd2
  } arb_state_e;

  localparam int TX_HOLD_DEF = 10;
  localparam int HOLD_CNT_W  = 4;

  // Only data commands touch memory; address commands are register updates.
  function automatic logic is_mem_cmd(input cmd_e c);
    return (c == CMD_WR_DATA) || (c == CMD_RD_DATA);
  endfunction

endpackage

// File: rtl/spi_mem_arb.sv
// Round-robin arbiter between the SPI pending request and the host port.
// Latency: grant state one cycle after a request is seen in IDLE; each access state lasts one cycle.
// Backpressure: requesters hold their request until their access state is reached.
module spi_mem_arb
  import spi_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic spi_req,
  input  logic host_req,
  output logic spi_acc,
  output logic host_acc
);

  arb_state_e state;
  arb_state_e state_nxt;
  logic       last_host;
  logic       last_host_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      last_host <= 1'b1;
    end else begin
      state     <= state_nxt;
      last_host <= last_host_nxt;
    end
  end

  always_comb begin
    state_nxt     = ARB_IDLE;
    last_host_nxt = last_host;
    spi_acc       = 1'b0;
    host_acc      = 1'b0;
    case (state)
      ARB_IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (spi_req && (!host_req || last_host)) begin
          state_nxt     = ARB_ACC_SPI;
          last_host_nxt = 1'b0;
        end else if (host_req) begin
          state_nxt     = ARB_ACC_HOST;
          last_host_nxt = 1'b1;
        end
      end
      ARB_ACC_SPI:  spi_acc  = 1'b1;
      ARB_ACC_HOST: host_acc = 1'b1;
      default:      state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI frame decoder plus shared single-port memory with host port; optional SPI_MEM_CTRL_AUTOINC_EN.
// Latency: frame edge E -> pending E+1 -> access E+1 -> tx_valid E+2; host grant next edge, rdata one after.
// Backpressure: one-deep SPI pending slot, extra frames dropped and flagged by sticky overrun.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = TX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [7:0]           host_rdata,
  output logic                 overrun
);

  localparam logic [ADDR_SIZE-1:0]  ADDR_ONE  = 1;
  localparam logic [HOLD_CNT_W-1:0] HOLD_INIT = HOLD_CNT_W'(TX_HOLD);
  localparam logic [HOLD_CNT_W-1:0] HOLD_ONE  = 1;

  logic [7:0] mem [MEM_DEPTH];

  logic                  rx_prev;
  logic                  accept;
  cmd_e                  cmd;
  logic [ADDR_SIZE-1:0]  payload_addr;
  logic                  mem_cmd;
  logic                  drop;
  logic                  load;

  logic                  pend_vld;
  logic                  pend_we;
  logic [ADDR_SIZE-1:0]  pend_addr;
  logic [7:0]            pend_data;

  logic [ADDR_SIZE-1:0]  wr_addr;
  logic [ADDR_SIZE-1:0]  rd_addr;
  logic [ADDR_SIZE-1:0]  wr_addr_eff;
  logic [ADDR_SIZE-1:0]  rd_addr_eff;

  logic                  spi_acc;
  logic                  host_acc;
  logic [HOLD_CNT_W-1:0] hold_cnt;

  assign accept       = rx_valid && !rx_prev;
  assign cmd          = cmd_e'(rx_data[9:8]);
  assign payload_addr = rx_data[ADDR_SIZE-1:0];
  assign mem_cmd      = accept && is_mem_cmd(cmd);
  // A frame landing in the same cycle the slot drains takes the slot instead of overrunning.
  assign drop         = mem_cmd && pend_vld && !spi_acc;
  assign load         = mem_cmd && !drop;

  spi_mem_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .spi_req  (pend_vld),
    .host_req (host_req),
    .spi_acc  (spi_acc),
    .host_acc (host_acc)
  );

  assign host_gnt = host_acc;
  assign tx_valid = (hold_cnt != '0);

  // Effective address after any increment from the access completing this cycle, so a
  // frame accepted in that same cycle captures the post-increment address.
  always_comb begin
    wr_addr_eff = wr_addr;
    rd_addr_eff = rd_addr;
`ifdef SPI_MEM_CTRL_AUTOINC_EN
    if (spi_acc && pend_we)  wr_addr_eff = wr_addr + ADDR_ONE;
    if (spi_acc && !pend_we) rd_addr_eff = rd_addr + ADDR_ONE;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      rx_prev <= rx_valid;
      wr_addr <= (accept && cmd == CMD_WR_ADDR) ? payload_addr : wr_addr_eff;
      rd_addr <= (accept && cmd == CMD_RD_ADDR) ? payload_addr : rd_addr_eff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_we   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        pend_vld  <= 1'b1;
        pend_we   <= (cmd == CMD_WR_DATA);
        pend_addr <= (cmd == CMD_WR_DATA) ? wr_addr_eff : rd_addr_eff;
        pend_data <= rx_data[7:0];
      end else if (spi_acc) begin
        pend_vld  <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= '0;
      hold_cnt <= '0;
    end else if (spi_acc && !pend_we) begin
      tx_data  <= mem[pend_addr];
      hold_cnt <= HOLD_INIT;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HOLD_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_acc && !host_we;
      if (host_acc && !host_we) host_rdata <= mem[host_addr];
    end
  end

  // Writes are keyed off the arbiter state, which reset clears asynchronously.
  always_ff @(posedge clk) begin
    if (spi_acc && pend_we)        mem[pend_addr] <= pend_data;
    else if (host_acc && host_we)  mem[host_addr] <= host_wdata;
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl against a frame-level memory/address model.
`timescale 1ns/1ps
module tb_spi_mem_ctrl;

  localparam int HOLD = 10;
`ifdef SPI_MEM_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_m [256];
  bit         known [256];
  logic [7:0] wr_m = '0;
  logic [7:0] rd_m = '0;

  always #5 clk = ~clk;

  spi_mem_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .overrun(overrun)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; rx_valid = 1'b0; host_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    wr_m = '0; rd_m = '0;
  endtask

  // One isolated frame; returns once any resulting memory write has completed.
  task automatic spi_frame(input logic [9:0] f);
    rx_data = f; rx_valid = 1'b1; tick(); rx_valid = 1'b0; tick(); tick();
    case (f[9:8])
      2'b00: wr_m = f[7:0];
      2'b10: rd_m = f[7:0];
      2'b01: begin mem_m[wr_m] = f[7:0]; known[wr_m] = 1'b1; if (AUTOINC) wr_m = wr_m + 8'd1; end
      default: ;
    endcase
  endtask

  task automatic spi_read_obs(output logic v1, output logic v2, output logic [7:0] d, output int len);
    rx_data = 10'h300; rx_valid = 1'b1; tick(); rx_valid = 1'b0; tick();
    v1 = tx_valid; tick();
    v2 = tx_valid; d = tx_data; len = 0;
    while (tx_valid && len < 40) begin len++; tick(); end
    if (AUTOINC) rd_m = rd_m + 8'd1;
  endtask

  task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d, output int wt,
                         output logic gnt_after, output logic rv, output logic [7:0] rd, output logic rv_after);
    host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1; wt = 0;
    do begin tick(); wt++; end while (!host_gnt && wt < 20);
    tick(); host_req = 1'b0;
    gnt_after = host_gnt; rv = host_rvalid; rd = host_rdata;
    tick(); rv_after = host_rvalid;
    if (we) begin mem_m[a] = d; known[a] = 1'b1; end
  endtask

  task automatic test_reset();
    int wt; logic ga, rv, rva; logic [7:0] rd;
    rst = 1'b1; tick(); tick();
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
    checks++; if (host_gnt !== 1'b0) begin failures++; $display("FAIL reset_host_gnt got=%0b exp=0", host_gnt); end
    checks++; if (host_rvalid !== 1'b0) begin failures++; $display("FAIL reset_host_rvalid got=%0b exp=0", host_rvalid); end
    checks++; if (host_rdata !== 8'h00) begin failures++; $display("FAIL reset_host_rdata got=%0h exp=0", host_rdata); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    rst = 1'b0; wr_m = '0; rd_m = '0;
    spi_frame(10'h1C3);
    host_op(1'b0, 8'h00, 8'h00, wt, ga, rv, rd, rva);
    checks++; if (rd !== 8'hC3) begin failures++; $display("FAIL reset_wr_addr_zero got=%0h exp=c3", rd); end
  endtask

  task automatic test_spi_basic();
    logic v1, v2; logic [7:0] d; int len;
    spi_frame(10'h012);
    spi_frame(10'h1A5);
    spi_frame(10'h212);
    spi_read_obs(v1, v2, d, len);
    checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL spi_rd_early got=%0b exp=0", v1); end
    checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL spi_rd_latency got=%0b exp=1", v2); end
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL spi_rd_data got=%0h exp=a5", d); end
    checks++; if (len != HOLD) begin failures++; $display("FAIL spi_rd_hold got=%0d exp=%0d", len, HOLD); end
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL spi_rd_retain got=%0h exp=a5", tx_data); end
  endtask

  task automatic test_rx_hold();
    int starts, high; logic prev; logic [7:0] exp;
    spi_frame(10'h212);
    exp = mem_m[rd_m]; starts = 0; high = 0; prev = tx_valid;
    rx_data = 10'h300; rx_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) rx_valid = 1'b0;
      tick();
      if (tx_valid && !prev) starts++;
      if (tx_valid) high++;
      prev = tx_valid;
    end
    if (AUTOINC) rd_m = rd_m + 8'd1;
    checks++; if (starts != 1) begin failures++; $display("FAIL held_rx_replies got=%0d exp=1", starts); end
    checks++; if (high != HOLD) begin failures++; $display("FAIL held_rx_hold got=%0d exp=%0d", high, HOLD); end
    checks++; if (tx_data !== exp) begin failures++; $display("FAIL held_rx_data got=%0h exp=%0h", tx_data, exp); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL held_rx_overrun got=%0b exp=0", overrun); end
  endtask

  task automatic test_tie();
    logic g1, g2, g3; logic [7:0] a_spi; int wt; logic ga, rv, rva; logic [7:0] rd;
    apply_reset();
    a_spi = wr_m;
    rx_data = 10'h155; rx_valid = 1'b1; tick();
    rx_valid = 1'b0; host_we = 1'b1; host_addr = 8'h41; host_wdata = 8'h66; host_req = 1'b1;
    tick(); g1 = host_gnt;
    tick(); g2 = host_gnt;
    tick(); g3 = host_gnt;
    tick(); host_req = 1'b0; tick();
    mem_m[a_spi] = 8'h55; known[a_spi] = 1'b1; if (AUTOINC) wr_m = wr_m + 8'd1;
    mem_m[8'h41] = 8'h66; known[8'h41] = 1'b1;
    checks++; if ({g1, g2, g3} !== 3'b001) begin failures++; $display("FAIL tie_spi_first gnt_seq got=%b exp=001", {g1, g2, g3}); end
    host_op(1'b0, a_spi, 8'h00, wt, ga, rv, rd, rva);
    checks++; if (rd !== 8'h55) begin failures++; $display("FAIL tie_spi_write got=%0h exp=55", rd); end
    host_op(1'b0, 8'h41, 8'h00, wt, ga, rv, rd, rva);
    checks++; if (rd !== 8'h66) begin failures++; $display("FAIL tie_host_write got=%0h exp=66", rd); end
    spi_frame(10'h177);
    a_spi = wr_m;
    rx_data = 10'h188; rx_valid = 1'b1; tick();
    rx_valid = 1'b0; host_we = 1'b0; host_addr = 8'h41; host_req = 1'b1;
    tick(); g1 = host_gnt;
    host_req = 1'b0; tick(); tick(); tick();
    mem_m[a_spi] = 8'h88; known[a_spi] = 1'b1; if (AUTOINC) wr_m = wr_m + 8'd1;
    checks++; if (g1 !== 1'b1) begin failures++; $display("FAIL tie_host_first got=%0b exp=1", g1); end
    host_op(1'b0, a_spi, 8'h00, wt, ga, rv, rd, rva);
    checks++; if (rd !== 8'h88) begin failures++; $display("FAIL tie_spi_second got=%0h exp=88", rd); end
  endtask

  task automatic test_host_rw();
    int wt; logic ga, rv, rva; logic [7:0] rd;
    host_op(1'b1, 8'h40, 8'h77, wt, ga, rv, rd, rva);
    checks++; if (wt != 1) begin failures++; $display("FAIL host_gnt_latency got=%0d exp=1", wt); end
    checks++; if (ga !== 1'b0) begin failures++; $display("FAIL host_gnt_pulse got=%0b exp=0", ga); end
    host_op(1'b0, 8'h40, 8'h00, wt, ga, rv, rd, rva);
    checks++; if (rv !== 1'b1) begin failures++; $display("FAIL host_rvalid got=%0b exp=1", rv); end
    checks++; if (rd !== 8'h77) begin failures++; $display("FAIL host_rdata got=%0h exp=77", rd); end
    checks++; if (rva !== 1'b0) begin failures++; $display("FAIL host_rvalid_pulse got=%0b exp=0", rva); end
  endtask

  task automatic test_overrun();
    int wt; logic ga, rv, rva; logic [7:0] rd;
    spi_frame(10'h030);
    rx_data = 10'h1AB; rx_valid = 1'b1; host_we = 1'b0; host_addr = 8'h41; host_req = 1'b1;
    tick(); rx_valid = 1'b0; host_req = 1'b0;
    tick(); rx_data = 10'h1CD; rx_valid = 1'b1;
    tick(); rx_valid = 1'b0;
    tick(); tick(); tick();
    mem_m[8'h30] = 8'hAB; known[8'h30] = 1'b1; if (AUTOINC) wr_m = wr_m + 8'd1;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%0b exp=1", overrun); end
    host_op(1'b0, 8'h30, 8'h00, wt, ga, rv, rd, rva);
    checks++; if (rd !== 8'hAB) begin failures++; $display("FAIL overrun_dropped_frame got=%0h exp=ab", rd); end
    repeat (20) tick();
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%0b exp=1", overrun); end
    apply_reset();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_rst got=%0b exp=0", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic v;
    spi_frame(10'h050);
    spi_frame(10'h250);
    rx_data = 10'h15A; rx_valid = 1'b1; tick();
    rx_valid = 1'b0; tick();
    rx_data = 10'h300; rx_valid = 1'b1; tick();
    rx_valid = 1'b0; tick(); tick();
    v = tx_valid; d = tx_data;
    mem_m[8'h50] = 8'h5A; known[8'h50] = 1'b1;
    if (AUTOINC) begin wr_m = wr_m + 8'd1; rd_m = rd_m + 8'd1; end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_no_overrun got=%0b exp=0", overrun); end
    checks++; if (v !== 1'b1) begin failures++; $display("FAIL b2b_reply_valid got=%0b exp=1", v); end
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL b2b_raw_data got=%0h exp=5a", d); end
    repeat (HOLD + 2) tick();
  endtask

  task automatic test_reset_mid();
    int wt; logic ga, rv, rva; logic [7:0] rd;
    spi_frame(10'h240);
    rx_data = 10'h300; rx_valid = 1'b1; tick();
    rx_valid = 1'b0; tick(); tick(); tick(); tick();
    rst = 1'b1; #1;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_hold_tx_valid got=%0b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_hold_tx_data got=%0h exp=0", tx_data); end
    tick(); rst = 1'b0; wr_m = '0; rd_m = '0;
    host_op(1'b1, 8'h60, 8'h11, wt, ga, rv, rd, rva);
    spi_frame(10'h060);
    rx_data = 10'h199; rx_valid = 1'b1; tick();
    rx_valid = 1'b0; tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0; wr_m = '0; rd_m = '0;
    host_op(1'b0, 8'h60, 8'h00, wt, ga, rv, rd, rva);
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL rst_mid_access_write got=%0h exp=11", rd); end
  endtask

  task automatic test_random();
    int wt, len, op; logic ga, rv, rva, v1, v2, k; logic [7:0] a, d, rd, exp;
    for (int i = 0; i < 16; i++) host_op(1'b1, 8'(i), 8'($urandom), wt, ga, rv, rd, rva);
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 5);
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      case (op)
        0: spi_frame({2'b00, a});
        1: spi_frame({2'b10, a});
        2: spi_frame({2'b01, d});
        3: begin
          exp = mem_m[rd_m]; k = known[rd_m];
          spi_read_obs(v1, v2, rd, len);
          checks++; if (v2 !== 1'b1 || len != HOLD) begin failures++; $display("FAIL rand_spi_reply iter=%0d valid=%0b len=%0d exp_len=%0d", i, v2, len, HOLD); end
          if (k) begin checks++; if (rd !== exp) begin failures++; $display("FAIL rand_spi_data iter=%0d got=%0h exp=%0h", i, rd, exp); end end
        end
        4: host_op(1'b1, a, d, wt, ga, rv, rd, rva);
        default: begin
          exp = mem_m[a]; k = known[a];
          host_op(1'b0, a, 8'h00, wt, ga, rv, rd, rva);
          checks++; if (rv !== 1'b1) begin failures++; $display("FAIL rand_host_rvalid iter=%0d got=%0b exp=1", i, rv); end
          if (k) begin checks++; if (rd !== exp) begin failures++; $display("FAIL rand_host_data iter=%0d got=%0h exp=%0h", i, rd, exp); end end
        end
      endcase
      repeat ($urandom_range(0, 3)) tick();
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rand_overrun got=%0b exp=0", overrun); end
  endtask

`ifdef SPI_MEM_CTRL_AUTOINC_EN
  task automatic test_autoinc();
    int wt, len; logic ga, rv, rva, v1, v2; logic [7:0] rd;
    spi_frame(10'h0FF);
    spi_frame(10'h111);
    spi_frame(10'h122);
    host_op(1'b0, 8'hFF, 8'h00, wt, ga, rv, rd, rva);
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL autoinc_mem_ff got=%0h exp=11", rd); end
    host_op(1'b0, 8'h00, 8'h00, wt, ga, rv, rd, rva);
    checks++; if (rd !== 8'h22) begin failures++; $display("FAIL autoinc_mem_00 got=%0h exp=22", rd); end
    spi_frame(10'h2FF);
    spi_read_obs(v1, v2, rd, len);
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL autoinc_rd_first got=%0h exp=11", rd); end
    spi_read_obs(v1, v2, rd, len);
    checks++; if (rd !== 8'h22) begin failures++; $display("FAIL autoinc_rd_wrap got=%0h exp=22", rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_spi_basic();
    test_rx_hold();
    test_tie();
    test_host_rw();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef SPI_MEM_CTRL_AUTOINC_EN
    test_autoinc();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
